vigenere_stream_cipher: RTL and testbench

- Streaming multi-key shift cipher and the successor to the single-shift character encryptor.
- Applies a per-character shift taken from a programmable key table of up to KEY_DEPTH entries, cycling through the table.
- Supports encrypt and decrypt modes and uses valid/ready handshakes on both sides.
- Sits between the character source (keyboard/UART buffer) and the alphanumeric display driver.

---
 rtl/cipher_pkg.sv | 35 +++
 rtl/cipher_shift_unit.sv | 59 +++++
 rtl/vigenere_stream_cipher.sv | 157 +++++++++++++++
 tb/tb_vigenere_stream_cipher.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared constants, character classes and classifier
// for the Vigenere stream cipher datapath.
package cipher_pkg;

  localparam logic [7:0] DIGIT_LO = 8'd48;
  localparam logic [7:0] DIGIT_HI = 8'd57;
  localparam logic [7:0] UPPER_LO = 8'd65;
  localparam logic [7:0] UPPER_HI = 8'd90;
  localparam logic [7:0] LOWER_LO = 8'd97;
  localparam logic [7:0] LOWER_HI = 8'd122;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    CLS_DIGIT,
    CLS_UPPER,
    CLS_LOWER,
    CLS_OTHER
  } char_class_t;

  function automatic char_class_t classify(
    input logic [7:0] c
  );
    char_class_t r;
    unique case (1'b1)
      (c >= DIGIT_LO && c <= DIGIT_HI): r = CLS_DIGIT;
      (c >= UPPER_LO && c <= UPPER_HI): r = CLS_UPPER;
      (c >= LOWER_LO && c <= LOWER_HI): r = CLS_LOWER;
      default:                          r = CLS_OTHER;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cipher_shift_unit.sv
// Combinational shift-and-wrap of one classified character.
// Shift is already reduced modulo the class alphabet size.
module cipher_shift_unit
  import cipher_pkg::*;
(
  input  logic [7:0]  i_data,
  input  char_class_t i_cls,
  input  logic [4:0]  i_shift,
  input  logic        i_mode,
  output logic [7:0]  o_data
);

  logic [8:0] w_base;
  logic [8:0] w_n;
  logic [8:0] w_hi;
  logic [8:0] w_c;
  logic [8:0] w_k;
  logic [8:0] w_sum;
  logic [8:0] w_dif;

  always_comb begin
    w_base = 9'd0;
    w_n    = 9'd0;
    unique case (i_cls)
      CLS_DIGIT: begin
        w_base = {1'b0, DIGIT_LO};
        w_n    = 9'd10;
      end
      CLS_UPPER: begin
        w_base = {1'b0, UPPER_LO};
        w_n    = 9'd26;
      end
      CLS_LOWER: begin
        w_base = {1'b0, LOWER_LO};
        w_n    = 9'd26;
      end
      default: ;
    endcase
  end

  assign w_c   = {1'b0, i_data};
  assign w_k   = {4'd0, i_shift};
  assign w_sum = w_c + w_k;
  assign w_dif = w_c - w_k;
  assign w_hi  = w_base + w_n - 9'd1;

  // shift < N, so one conditional wrap suffices
  always_comb begin
    o_data = i_data;
    if (i_cls != CLS_OTHER) begin
      if (i_mode == MODE_ENC) begin
        o_data = 8'((w_sum > w_hi) ? (w_sum - w_n) : w_sum);
      end else begin
        o_data = 8'((w_dif < w_base) ? (w_dif + w_n) : w_dif);
      end
    end
  end

endmodule

// File: rtl/vigenere_stream_cipher.sv
// Streaming multi-key shift cipher: S1 classifies and picks
// the key shift, S2 applies it; valid/ready on both sides.
module vigenere_stream_cipher
  import cipher_pkg::*;
#(
  parameter int KEY_DEPTH     = 16,
  parameter int DATA_W        = 8,
  parameter bit SKIP_NONALNUM = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_wr,
  input  logic [$clog2(KEY_DEPTH)-1:0] key_addr,
  input  logic [7:0]                 key_shift,
  input  logic [$clog2(KEY_DEPTH):0] key_len,
  output logic                       key_busy,
  input  logic                       mode,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_last
);

  localparam int AW = $clog2(KEY_DEPTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      r_state;
  logic        r_mode;
  logic [AW-1:0] r_idx;
  logic [3:0]  r_k10 [KEY_DEPTH];
  logic [4:0]  r_k26 [KEY_DEPTH];

  logic        r_s1_full;
  logic        r_s1_last;
  logic        r_s1_mode;
  logic [7:0]  r_s1_data;
  char_class_t r_s1_cls;
  logic [4:0]  r_s1_shift;

  logic        r_s2_full;
  logic        r_s2_last;
  logic [7:0]  r_s2_data;

  logic        w_key_acc;
  logic        w_s_acc;
  logic        w_s1_adv;
  logic        w_s2_adv;
  logic        w_mode;
  logic        w_alnum;
  char_class_t w_cls;
  logic [4:0]  w_shift;
  logic [AW:0] w_eff_len;
  logic [AW:0] w_idx_inc;
  logic [AW-1:0] w_idx_next;
  logic [7:0]  w_s2_data;

  assign key_busy = (r_state == ST_RUN) || r_s1_full || r_s2_full;
  assign w_key_acc = key_wr && !key_busy;

  assign w_s2_adv = !r_s2_full || m_ready;
  assign w_s1_adv = r_s1_full && w_s2_adv;
  // an accepted key write blocks input for that one cycle
  assign s_ready  = (!r_s1_full || w_s2_adv) && !w_key_acc;
  assign w_s_acc  = s_valid && s_ready;

  assign w_mode  = (r_state == ST_IDLE) ? mode : r_mode;
  assign w_cls   = classify(s_data);
  assign w_alnum = (w_cls != CLS_OTHER);
  assign w_shift = (w_cls == CLS_DIGIT) ? {1'b0, r_k10[r_idx]}
                                        : r_k26[r_idx];

  assign w_eff_len  = (key_len == '0) ? {{AW{1'b0}}, 1'b1} : key_len;
  assign w_idx_inc  = {1'b0, r_idx} + {{AW{1'b0}}, 1'b1};
  assign w_idx_next = (w_idx_inc >= w_eff_len) ? '0 : w_idx_inc[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KEY_DEPTH; i++) begin
        r_k10[i] <= '0;
        r_k26[i] <= '0;
      end
    end else if (w_key_acc) begin
      r_k10[key_addr] <= 4'(key_shift % 8'd10);
      r_k26[key_addr] <= 5'(key_shift % 8'd26);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_ENC;
      r_idx   <= '0;
    end else if (w_key_acc) begin
      r_idx <= '0;
    end else if (w_s_acc) begin
      r_mode  <= w_mode;
      r_state <= s_last ? ST_IDLE : ST_RUN;
      if (s_last) begin
        r_idx <= '0;
      end else if (w_alnum || !SKIP_NONALNUM) begin
        r_idx <= w_idx_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_full  <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_mode  <= MODE_ENC;
      r_s1_data  <= '0;
      r_s1_cls   <= CLS_OTHER;
      r_s1_shift <= '0;
    end else if (w_s_acc) begin
      r_s1_full  <= 1'b1;
      r_s1_last  <= s_last;
      r_s1_mode  <= w_mode;
      r_s1_data  <= s_data;
      r_s1_cls   <= w_cls;
      r_s1_shift <= w_shift;
    end else if (w_s1_adv) begin
      r_s1_full <= 1'b0;
    end
  end

  cipher_shift_unit u_shift (
    .i_data  (r_s1_data),
    .i_cls   (r_s1_cls),
    .i_shift (r_s1_shift),
    .i_mode  (r_s1_mode),
    .o_data  (w_s2_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_full <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_data <= '0;
    end else if (w_s1_adv) begin
      r_s2_full <= 1'b1;
      r_s2_last <= r_s1_last;
      r_s2_data <= w_s2_data;
    end else if (m_ready) begin
      r_s2_full <= 1'b0;
    end
  end

  assign m_valid = r_s2_full;
  assign m_last  = r_s2_last;
  assign m_data  = r_s2_data;

endmodule

// File: tb/tb_vigenere_stream_cipher.sv
// Bench for vigenere_stream_cipher: directed literal cases plus
// randomized messages checked against a modular-arithmetic model.
module tb_vigenere_stream_cipher;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_wr;
  logic [3:0] key_addr;
  logic [7:0] key_shift;
  logic [4:0] key_len;
  logic       key_busy;
  logic       mode;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  always #5 clk = ~clk;

  vigenere_stream_cipher dut (
    .clk       (clk),
    .rst       (rst),
    .key_wr    (key_wr),
    .key_addr  (key_addr),
    .key_shift (key_shift),
    .key_len   (key_len),
    .key_busy  (key_busy),
    .mode      (mode),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // reference model state
  int         mk [16];
  int         m_idx = 0;
  bit         m_in_msg = 0;
  bit         m_mode = 0;
  logic [8:0] exp_q [$];
  logic [8:0] cap [$];
  bit         lat_arm = 0;
  int         t_acc0 = -1;
  int         t_val0 = -1;

  function automatic bit is_alnum(input logic [7:0] c);
    return (c >= 48 && c <= 57) || (c >= 65 && c <= 90) ||
           (c >= 97 && c <= 122);
  endfunction

  function automatic logic [7:0] model_out(input logic [7:0] c,
                                           input int sh, input bit dec);
    int base;
    int n;
    int off;
    if (c >= 48 && c <= 57) begin
      base = 48; n = 10;
    end else if (c >= 65 && c <= 90) begin
      base = 65; n = 26;
    end else if (c >= 97 && c <= 122) begin
      base = 97; n = 26;
    end else begin
      return c;
    end
    off = int'(c) - base;
    if (dec) off = (off - (sh % n) + n) % n;
    else     off = (off + sh) % n;
    return 8'(base + off);
  endfunction

  task automatic model_accept(input logic [7:0] c, input bit last,
                              input bit md);
    int eff;
    if (!m_in_msg) m_mode = md;
    exp_q.push_back({last, model_out(c, mk[m_idx], m_mode)});
    eff = (key_len == 0) ? 1 : int'(key_len);
    if (last) begin
      m_idx = 0;
      m_in_msg = 0;
    end else begin
      m_in_msg = 1;
      if (is_alnum(c)) m_idx = (m_idx + 1) % eff;
    end
    if (lat_arm && t_acc0 < 0) t_acc0 = cyc;
  endtask

  // m_ready driver: 0 always, 1 pattern 1,0,0,1, 2 random, 3 held low
  int rdy_mode = 0;
  int ph = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: begin
          m_ready = (ph % 4 == 0) || (ph % 4 == 3);
          ph++;
        end
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // output compare process
  bit         stall = 0;
  logic [8:0] held;
  logic [8:0] e_out;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stall = 0;
      end else begin
        if (stall)
          check("hold", {m_valid, m_last, m_data}, {1'b1, held});
        if (lat_arm && m_valid && t_val0 < 0) t_val0 = cyc;
        if (m_valid && m_ready) begin
          cap.push_back({m_last, m_data});
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL spurious: got %0h expected none",
                     {m_last, m_data});
          end else begin
            e_out = exp_q.pop_front();
            check("out", {m_last, m_data}, e_out);
          end
        end
        stall = m_valid && !m_ready;
        held = {m_last, m_data};
      end
    end
  end

  // all drive tasks start and end on a negedge
  task automatic send_char(input logic [7:0] c, input bit last,
                           input bit md);
    int t = 0;
    bit done = 0;
    s_valid = 1'b1;
    s_data = c;
    s_last = last;
    mode = md;
    while (!done) begin
      #1;
      if (s_ready) begin
        model_accept(c, last, md);
        done = 1;
      end else if (++t > 200) begin
        n_chk++;
        $display("FAIL accept-timeout: got s_ready=0 expected 1");
        done = 1;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input bit md,
                            input bit fin);
    for (int i = 0; i < q.size(); i++)
      send_char(q[i], fin && (i == q.size() - 1), md);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit md, input bit fin);
    logic [7:0] q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_bytes(q, md, fin);
  endtask

  task automatic write_key(input int a, input int sh, input bit exp_busy);
    key_wr = 1'b1;
    key_addr = 4'(a);
    key_shift = 8'(sh);
    #1;
    check("key_busy@wr", key_busy, exp_busy);
    if (!exp_busy) begin
      mk[a] = sh;
      m_idx = 0;
    end
    @(negedge clk);
    key_wr = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_valid || key_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (t < 3000) n_pass++;
    else $display("FAIL drain-timeout: got %0d pending expected 0",
                  exp_q.size());
  endtask

  task automatic check_cap(input string nm, input string e);
    string got = "";
    foreach (cap[i]) got = $sformatf("%s%c", got, cap[i][7:0]);
    n_chk++;
    if (got == e) n_pass++;
    else $display("FAIL %s: got \"%s\" expected \"%s\"", nm, got, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    foreach (mk[i]) mk[i] = 0;
    rst = 1'b1;
    key_wr = 1'b0;
    key_addr = '0;
    key_shift = '0;
    key_len = 5'd1;
    mode = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst m_valid", m_valid, 0);
    check("rst m_data", m_data, 0);
    check("rst m_last", m_last, 0);
    check("rst key_busy", key_busy, 0);
    @(negedge clk);

    // encrypt with key {3,27}
    write_key(0, 3, 0);
    write_key(1, 27, 0);
    key_len = 5'd2;
    cap.delete();
    lat_arm = 1;
    send_str("Az9!", 0, 1);
    drain();
    lat_arm = 0;
    check_cap("enc Az9!", "Da2!");
    check("latency", t_val0 - t_acc0, 2);
    check("m_last pattern",
          {cap[0][8], cap[1][8], cap[2][8], cap[3][8]}, 4'b0001);

    cap.delete();
    send_str("Da2!", 1, 1);
    drain();
    check_cap("dec Da2!", "Az9!");

    // non-alnum does not consume a key entry
    write_key(0, 1, 0);
    write_key(1, 2, 0);
    cap.delete();
    send_str("a-a", 0, 1);
    drain();
    check_cap("skip a-a", "b-c");

    // key write wins over a simultaneous first beat
    s_valid = 1'b1;
    s_data = 8'h62;
    s_last = 1'b0;
    key_wr = 1'b1;
    key_addr = 4'd0;
    key_shift = 8'd5;
    #1;
    check("kw s_ready", s_ready, 0);
    check("kw key_busy", key_busy, 0);
    mk[0] = 5;
    m_idx = 0;
    @(negedge clk);
    key_wr = 1'b0;
    cap.delete();
    send_char(8'h62, 0, 0);
    send_char(8'h62, 1, 0);
    s_valid = 1'b0;
    s_last = 1'b0;
    drain();
    check_cap("kw wins", "gd");

    // key_len 0 behaves as 1
    key_len = 5'd0;
    cap.delete();
    send_str("aa", 0, 1);
    drain();
    check_cap("len0", "ff");

    // 32-char stream under 1,0,0,1 backpressure
    key_len = 5'd2;
    rdy_mode = 1;
    ph = 0;
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(8'($urandom_range(33, 126)));
    cap.delete();
    send_bytes(q, 0, 1);
    drain();
    rdy_mode = 0;
    check("count32", cap.size(), 32);

    // key write while busy is dropped
    write_key(0, 7, 0);
    write_key(1, 11, 0);
    write_key(2, 30, 0);
    key_len = 5'd3;
    send_str("Hello", 0, 0);
    write_key(0, 200, 1);
    send_str(" World 42", 0, 1);
    drain();
    write_key(0, 5, 0);
    key_len = 5'd1;
    cap.delete();
    send_str("aa", 0, 1);
    drain();
    check_cap("new key", "ff");

    // reset with two characters in flight
    key_len = 5'd2;
    write_key(0, 9, 0);
    rdy_mode = 3;
    @(negedge clk);
    send_str("xy", 0, 0);
    rst = 1'b1;
    exp_q.delete();
    foreach (mk[i]) mk[i] = 0;
    m_idx = 0;
    m_in_msg = 0;
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    #1;
    check("post-rst m_valid", m_valid, 0);
    check("post-rst key_busy", key_busy, 0);
    @(negedge clk);
    key_len = 5'd1;
    cap.delete();
    send_str("Hi9", 0, 1);
    drain();
    check_cap("post-rst pass", "Hi9");

    // randomized messages
    for (int m = 0; m < 40; m++) begin
      if (m % 5 == 0) begin
        drain();
        for (int a = 0; a < 16; a++) write_key(a, $urandom_range(0, 255), 0);
        key_len = 5'($urandom_range(0, 16));
      end
      rdy_mode = 2;
      q.delete();
      for (int i = 0; i < $urandom_range(1, 10); i++) begin
        if ($urandom_range(0, 3) != 0) q.push_back(8'($urandom_range(32, 126)));
        else q.push_back(8'($urandom_range(0, 255)));
      end
      send_bytes(q, 1'($urandom_range(0, 1)), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    rdy_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
